toggle_handshake_rx: RTL and testbench
======================================

TOGGLE_HANDSHAKE_RX -- requirements
Module: toggle_handshake_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of the transferred data word.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4, number of synchronizer flops on req_tgl.
REQ-003 SHALL have port clk  input  1  receiver-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_tgl  input  1  request toggle from the sender domain; each level change is one transfer request.
REQ-006 SHALL have port data_in  input  DATA_W  sender data; held stable by the sender from the req_tgl change until ack_tgl changes.
REQ-007 SHALL have port ack_tgl  output  1  acknowledge toggle to the sender; registered, changes once per completed transfer.
REQ-008 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-009 SHALL have port out_data  output  DATA_W  captured word; stable while out_valid=1.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1 on a rising clk edge.
REQ-011 SHALL have port xfer_cnt  output  8  count of completed transfers.
REQ-012 SHALL have port proto_err  output  1  sticky flag; sender toggled req_tgl before receiving ack_tgl.

Function
REQ-013 SHALL pass req_tgl through a SYNC_STAGES-deep flop chain, then one history flop; req_event = last sync stage XOR history flop.
REQ-014 SHALL use no combinational path from req_tgl or data_in to any output.
REQ-015 SHALL implement a two-state FSM: IDLE and HOLD; reset state IDLE.
REQ-016 IDLE with req_event=1 SHALL capture data_in into out_data, set out_valid=1, go to HOLD on the same edge.
REQ-017 IDLE with req_event=0 SHALL hold all outputs unchanged.
REQ-018 HOLD with out_ready=1 SHALL clear out_valid, toggle ack_tgl, increment xfer_cnt, go to IDLE on the same edge.
REQ-019 HOLD with out_ready=0 SHALL keep out_valid=1 and out_data unchanged indefinitely.
REQ-020 Latency: a req_tgl change stable before edge k SHALL produce out_valid=1 after edge k+SYNC_STAGES (edge k+2 for default).
REQ-021 Minimum turnaround SHALL be one cycle in HOLD: out_ready tied high gives out_valid high for exactly one cycle.
REQ-022 A req_event while in HOLD SHALL set proto_err=1, SHALL NOT overwrite out_data, SHALL NOT create an extra transfer.
REQ-023 A req_event arriving on the same edge HOLD exits SHALL be treated as occurring in HOLD (REQ-022 applies).
REQ-024 proto_err SHALL remain 1 until reset_n asserted.
REQ-025 xfer_cnt SHALL wrap 255 -> 0 with no flag.
REQ-026 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-027 reset_n=0 SHALL immediately, without clk, force: sync chain and history flop 0, state IDLE, ack_tgl 0, out_valid 0, out_data 0, xfer_cnt 0, proto_err 0.
REQ-028 Reset mid-transfer SHALL discard the held word and emit no ack toggle; the sender is reset concurrently, both sides restarting at level 0.
REQ-029 After reset_n deasserts, req_tgl=0 SHALL produce no req_event.
REQ-030 Reset release synchronization to clk SHALL be provided externally.

Verification
REQ-031 Reset, req_tgl 0->1 with data_in=0xA5, out_ready=1 -> out_valid=1 exactly 2 edges later for 1 cycle, out_data=0xA5, ack_tgl 0->1, xfer_cnt=1.
REQ-032 out_ready=0 for 10 cycles after out_valid rises -> out_valid and out_data=0x3C held 10 cycles, ack_tgl unchanged; out_ready=1 -> ack toggles next edge.
REQ-033 Sender toggles twice (0x11, then 0x22) before ack, out_ready=0 -> proto_err=1, out_data stays 0x11, xfer_cnt=1 after out_ready=1.
REQ-034 256 back-to-back toggle/ack transfers, incrementing data 0x00..0xFF -> every word delivered in order once, xfer_cnt wraps to 0, ack_tgl back to 0.
REQ-035 reset_n pulsed low while in HOLD with out_data=0x7E -> out_valid=0, out_data=0, ack_tgl=0, proto_err=0 with no clk edge.
REQ-036 SYNC_STAGES=3, single toggle -> out_valid rises 3 edges after the sampled req_tgl change.

Source files
------------

// File: rtl/toggle_handshake_rx.sv
// Receiver half of a toggle (2-phase) clock-domain-crossing handshake.
// Synchronizes req_tgl, captures data_in into a one-word output buffer and acks once it is consumed.
module toggle_handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_tgl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [7:0]        xfer_cnt,
  output logic              proto_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
    $error("toggle_handshake_rx: SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic                   req_event_s;

  logic [0:0]             state_r;
  logic [0:0]             state_nxt_s;
  logic                   ack_r;
  logic                   ack_nxt_s;
  logic                   valid_r;
  logic                   valid_nxt_s;
  logic [DATA_W-1:0]      data_r;
  logic [DATA_W-1:0]      data_nxt_s;
  logic [7:0]             cnt_r;
  logic [7:0]             cnt_nxt_s;
  logic                   err_r;
  logic                   err_nxt_s;

  // Request synchronizer chain plus history flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], req_tgl};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign req_event_s = sync_r[SYNC_STAGES-1] ^ hist_r;

  // Next-state logic; a request seen while holding is a sender protocol error and is dropped.
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = ack_r;
    valid_nxt_s = valid_r;
    data_nxt_s  = data_r;
    cnt_nxt_s   = cnt_r;
    err_nxt_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (req_event_s) begin
          data_nxt_s  = data_in;
          valid_nxt_s = 1'b1;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (req_event_s) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
        if (out_ready) begin
          valid_nxt_s = 1'b0;
          ack_nxt_s   = ~ack_r;
          cnt_nxt_s   = cnt_r + 8'd1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      ack_r   <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      cnt_r   <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= ack_nxt_s;
      valid_r <= valid_nxt_s;
      data_r  <= data_nxt_s;
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign ack_tgl   = ack_r;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign xfer_cnt  = cnt_r;
  assign proto_err = err_r;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Self-checking bench for toggle_handshake_rx: vector table, directed corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_toggle_handshake_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req, rdy;
  logic [7:0] din;
  logic       ack, valid;
  logic [7:0] dout, cnt;
  logic       err;

  logic       req3, rdy3;
  logic [7:0] din3;
  logic       ack3, valid3;
  logic [7:0] dout3, cnt3;
  logic       err3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .req_tgl(req), .data_in(din),
    .ack_tgl(ack), .out_valid(valid), .out_data(dout), .out_ready(rdy),
    .xfer_cnt(cnt), .proto_err(err)
  );

  toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req_tgl(req3), .data_in(din3),
    .ack_tgl(ack3), .out_valid(valid3), .out_data(dout3), .out_ready(rdy3),
    .xfer_cnt(cnt3), .proto_err(err3)
  );

  typedef struct {
    logic       rst;
    logic       req;
    logic [7:0] din;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       ea;
    logic [7:0] ec;
    logic       ee;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [7:0] d,
                            input logic a, input logic [7:0] c, input logic e);
    check({tag, " out_valid"}, {31'd0, valid}, {31'd0, v});
    check({tag, " out_data"},  {24'd0, dout},  {24'd0, d});
    check({tag, " ack_tgl"},   {31'd0, ack},   {31'd0, a});
    check({tag, " xfer_cnt"},  {24'd0, cnt},   {24'd0, c});
    check({tag, " proto_err"}, {31'd0, err},   {31'd0, e});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic restart;
    req = 1'b0; rdy = 1'b0; din = 8'h00;
    req3 = 1'b0; rdy3 = 1'b0; din3 = 8'h00;
    step;
    pulse_reset;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (!valid && k < budget) begin
      step;
      k++;
    end
    check({tag, " valid within budget"}, {31'd0, valid}, 32'd1);
  endtask

  // Behavioural model state for the random phase
  logic       lv[$];
  logic       m_valid, m_ack, m_err;
  logic [7:0] m_data, m_cnt;

  function automatic logic lv_at(input int i);
    return (i < 0) ? 1'b0 : lv[i];
  endfunction

  initial begin
    reset_n = 1'b0;
    req = 1'b0; rdy = 1'b0; din = 8'h00;
    req3 = 1'b0; rdy3 = 1'b0; din3 = 8'h00;
    #1;
    check_outs("reset", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);

    // rst req din rdy | valid data ack cnt err
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 8'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 8'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 8'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 8'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 8'd0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 8'd1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 8'd1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 8'd1, 1'b1};

    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; din = tbl[i].din; rdy = tbl[i].rdy;
      if (tbl[i].rst) pulse_reset;
      step;
      check_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ea, tbl[i].ec, tbl[i].ee);
    end

    // Consumer stalls ten cycles; word and ack must hold, then ack on the accepting edge
    restart;
    req = 1'b1; din = 8'h3C; rdy = 1'b0;
    wait_valid("stall", 10);
    for (int i = 0; i < 10; i++) begin
      step;
      check_outs($sformatf("stall%0d", i), 1'b1, 8'h3C, 1'b0, 8'd0, 1'b0);
    end
    rdy = 1'b1;
    step;
    check_outs("stall release", 1'b0, 8'h3C, 1'b1, 8'd1, 1'b0);

    // 256 back-to-back transfers: in-order delivery, single valid cycle each, counter wrap
    restart;
    rdy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic prev_ack, done;
      logic [7:0] got;
      int nv;
      din = i[7:0];
      req = ~req;
      prev_ack = ack; done = 1'b0; nv = 0; got = 8'h00;
      for (int k = 0; k < 20 && !done; k++) begin
        step;
        if (valid) begin
          nv++;
          got = dout;
        end
        if (ack != prev_ack) done = 1'b1;
      end
      check($sformatf("b2b%0d ack", i), {31'd0, done}, 32'd1);
      check($sformatf("b2b%0d data", i), {24'd0, got}, i);
      check($sformatf("b2b%0d once", i), nv, 32'd1);
    end
    check("b2b wrap cnt", {24'd0, cnt}, 32'd0);
    check("b2b final ack", {31'd0, ack}, 32'd0);

    // Asynchronous reset while holding a word with proto_err set
    restart;
    req = 1'b1; din = 8'h7E;
    wait_valid("arst", 10);
    req = 1'b0;
    step; step; step;
    check("arst pre err", {31'd0, err}, 32'd1);
    check("arst pre data", {24'd0, dout}, 32'h7E);
    reset_n = 1'b0;
    #1;
    check_outs("arst", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      check($sformatf("post-reset quiet%0d", i), {31'd0, valid}, 32'd0);
    end

    // Three-stage synchronizer latency
    restart;
    req3 = 1'b1; din3 = 8'h5A;
    step; step; step;
    check("sync3 early valid", {31'd0, valid3}, 32'd0);
    step;
    check("sync3 valid", {31'd0, valid3}, 32'd1);
    check("sync3 data", {24'd0, dout3}, 32'h5A);
    check("sync3 ack", {31'd0, ack3}, 32'd0);
    check("sync3 cnt", {24'd0, cnt3}, 32'd0);
    check("sync3 err", {31'd0, err3}, 32'd0);

    // Random traffic against the behavioural model
    restart;
    lv.delete();
    m_valid = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_data = 8'h00; m_cnt = 8'd0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int  e;
      logic ev;
      if ((req == ack && $urandom_range(2) == 0) || $urandom_range(199) == 0) begin
        req = ~req;
        din = 8'($urandom);
      end
      rdy = 1'($urandom_range(1));
      @(posedge clk);
      lv.push_back(req);
      e  = lv.size() - 1;
      ev = lv_at(e - 2) ^ lv_at(e - 3);
      if (!m_valid) begin
        if (ev) begin
          m_valid = 1'b1;
          m_data  = din;
        end
      end else begin
        if (ev) m_err = 1'b1;
        if (rdy) begin
          m_valid = 1'b0;
          m_ack   = ~m_ack;
          m_cnt   = m_cnt + 8'd1;
        end
      end
      #1;
      check($sformatf("rand%0d {valid,data,ack,cnt,err}", cyc),
            {13'd0, valid, dout, ack, cnt, err},
            {13'd0, m_valid, m_data, m_ack, m_cnt, m_err});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
